// File: rtl/cntr_fsm_param_if.sv
// Control/data bundle for cntr_fsm_param: command inputs toward the counter, registered results back.
interface cntr_fsm_param_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              load;
    logic              en;
    logic              inc;
    logic              sat;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  d_in;
    logic [WIDTH-1:0]  d_out;
    logic [2:0]        state;
    logic              ovf;
    logic              udf;

    modport master (
        output load, en, inc, sat, step, d_in,
        input  d_out, state, ovf, udf
    );

    modport slave (
        input  load, en, inc, sat, step, d_in,
        output d_out, state, ovf, udf
    );
endinterface

// File: rtl/cntr_fsm_param.sv
// Parametrised up/down/load counter with Moore state register and registered ovf/udf pulses.
// Latency: 1 cycle from sampled inputs to d_out/state/flags.
// Backpressure: none; a new command is accepted on every rising edge.
module cntr_fsm_param #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    cntr_fsm_param_if.slave     bus
);

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_LOAD = 3'b001;
    localparam logic [2:0] S_INC  = 3'b010;
    localparam logic [2:0] S_DEC  = 3'b011;
    localparam logic [2:0] S_HOLD = 3'b100;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // One guard bit above the count: sum[WIDTH] marks overflow, diff[WIDTH] marks borrow.
    assign step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, bus.step};
    assign sum    = {1'b0, cnt_q} + step_x;
    assign diff   = {1'b0, cnt_q} - step_x;

    always_comb begin
        state_d = S_IDLE;
        if (state_q > S_HOLD) begin
            state_d = S_IDLE;
        end else begin
            casez ({bus.load, bus.en, bus.inc})
                3'b1??:  state_d = S_LOAD;
                3'b00?:  state_d = S_HOLD;
                3'b011:  state_d = S_INC;
                3'b010:  state_d = S_DEC;
                default: state_d = 3'bxxx;
            endcase
        end
    end

    // Datapath is keyed on the state being entered, so action and state land on the same edge.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        case (state_d)
            S_LOAD: cnt_d = bus.d_in;
            S_INC: begin
                if (sum[WIDTH]) begin
                    ovf_d = 1'b1;
                    cnt_d = bus.sat ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                end else begin
                    cnt_d = sum[WIDTH-1:0];
                end
            end
            S_DEC: begin
                if (diff[WIDTH]) begin
                    udf_d = 1'b1;
                    cnt_d = bus.sat ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
                end else begin
                    cnt_d = diff[WIDTH-1:0];
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.d_out = cnt_q;
    assign bus.state = state_q;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;

endmodule

// File: tb/tb_cntr_fsm_param.sv
// Bench for cntr_fsm_param: an 8-bit and a 4-bit instance share clock and reset, scoreboard-checked.
module tb_cntr_fsm_param;

    typedef struct {
        bit ld;
        bit en;
        bit inc;
        bit sat;
        int step;
        int din;
    } stim_t;

    typedef struct {
        int d;
        int st;
        bit o;
        bit u;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    cntr_fsm_param_if #(.WIDTH(8), .STEP_W(4)) b8 ();
    cntr_fsm_param_if #(.WIDTH(4), .STEP_W(2)) b4 ();

    cntr_fsm_param #(.WIDTH(8), .STEP_W(4)) u8 (.clk(clk), .reset_n(reset_n), .bus(b8));
    cntr_fsm_param #(.WIDTH(4), .STEP_W(2)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4));

    exp_t q8[$];
    exp_t q4[$];
    int   m8 = 0;
    int   m4 = 0;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic stim_t mk(bit ld, bit en, bit inc, bit sat, int step, int din);
        stim_t s;
        s.ld = ld; s.en = en; s.inc = inc; s.sat = sat; s.step = step; s.din = din;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.ld   = ($urandom_range(0, 7) == 0);
        s.en   = ($urandom_range(0, 5) != 0);
        s.inc  = ($urandom_range(0, 1) == 1);
        s.sat  = ($urandom_range(0, 1) == 1);
        s.step = int'($urandom_range(0, 15));
        s.din  = int'($urandom_range(0, 255));
        return s;
    endfunction

    // Reference: counter value as a plain integer in [0, 2^w-1], step truncated to the port width.
    function automatic exp_t model(int w, int sw, stim_t s, int cnt);
        exp_t e;
        int   mx;
        int   st;
        mx  = (1 << w) - 1;
        st  = s.step & ((1 << sw) - 1);
        e.o = 1'b0;
        e.u = 1'b0;
        e.d = cnt;
        if (s.ld) begin
            e.st = 1;
            e.d  = s.din & mx;
        end else if (!s.en) begin
            e.st = 4;
        end else if (s.inc) begin
            e.st = 2;
            if (cnt + st > mx) begin
                e.o = 1'b1;
                e.d = s.sat ? mx : cnt + st - (mx + 1);
            end else begin
                e.d = cnt + st;
            end
        end else begin
            e.st = 3;
            if (st > cnt) begin
                e.u = 1'b1;
                e.d = s.sat ? 0 : cnt - st + mx + 1;
            end else begin
                e.d = cnt - st;
            end
        end
        return e;
    endfunction

    task automatic cmp(string nm, int d, int st, bit o, bit u, exp_t e);
        n_vec++;
        if (d != e.d || st != e.st || o != e.o || u != e.u) begin
            n_err++;
            $display("FAIL %s @%0t: got d_out=%0h state=%0d ovf=%0b udf=%0b, want d_out=%0h state=%0d ovf=%0b udf=%0b",
                     nm, $time, d, st, o, u, e.d, e.st, e.o, e.u);
        end
    endtask

    // Applies one command to both instances at a falling edge and queues the expected result.
    task automatic drive(stim_t a, stim_t b);
        exp_t e;
        b8.load = a.ld; b8.en = a.en; b8.inc = a.inc; b8.sat = a.sat;
        b8.step = a.step[3:0];
        b8.d_in = a.din[7:0];
        b4.load = b.ld; b4.en = b.en; b4.inc = b.inc; b4.sat = b.sat;
        b4.step = b.step[1:0];
        b4.d_in = b.din[3:0];
        e = model(8, 4, a, m8);
        m8 = e.d;
        q8.push_back(e);
        e = model(4, 2, b, m4);
        m4 = e.d;
        q4.push_back(e);
        @(negedge clk);
    endtask

    task automatic drive8(stim_t a);
        drive(a, rnd());
    endtask

    task automatic drive4(stim_t b);
        drive(rnd(), b);
    endtask

    task automatic check_reset(string nm);
        exp_t z;
        z.d = 0; z.st = 0; z.o = 1'b0; z.u = 1'b0;
        cmp({nm, "_w8"}, int'(b8.d_out), int'(b8.state), b8.ovf, b8.udf, z);
        cmp({nm, "_w4"}, int'(b4.d_out), int'(b4.state), b4.ovf, b4.udf, z);
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (reset_n) begin
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    cmp("w8", int'(b8.d_out), int'(b8.state), b8.ovf, b8.udf, e);
                end
                if (q4.size() > 0) begin
                    e = q4.pop_front();
                    cmp("w4", int'(b4.d_out), int'(b4.state), b4.ovf, b4.udf, e);
                end
            end
        end
    end

    initial begin
        b8.load = 1'b0; b8.en = 1'b0; b8.inc = 1'b0; b8.sat = 1'b0; b8.step = '0; b8.d_in = '0;
        b4.load = 1'b0; b4.en = 1'b0; b4.inc = 1'b0; b4.sat = 1'b0; b4.step = '0; b4.d_in = '0;

        #1 reset_n = 1'b0;
        #1 check_reset("rst_init");
        @(negedge clk);
        reset_n = 1'b1;

        drive8(mk(1, 0, 0, 0, 0, 'h37));
        drive8(mk(0, 1, 1, 0, 0, 0));

        // Asynchronous reset between edges while the counter sits at 8'h37.
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset("rst_mid");
        m8 = 0;
        m4 = 0;
        @(negedge clk);
        reset_n = 1'b1;

        drive8(mk(1, 0, 0, 0, 0, 'hA5));
        drive8(mk(1, 1, 1, 0, 0, 'hFD));
        drive8(mk(0, 1, 1, 0, 4, 0));
        drive8(mk(0, 1, 1, 0, 1, 0));
        drive8(mk(1, 1, 0, 1, 0, 'h03));
        drive8(mk(0, 1, 0, 1, 5, 0));
        drive8(mk(0, 1, 0, 1, 5, 0));
        drive8(mk(0, 1, 0, 1, 0, 0));
        drive8(mk(1, 0, 1, 0, 0, 'h10));
        repeat (3) drive8(mk(0, 0, 1, 0, 3, 0));
        drive8(mk(1, 0, 1, 0, 0, 'h77));
        drive8(mk(1, 1, 1, 1, 0, 'hFB));
        drive8(mk(0, 1, 1, 1, 4, 0));
        drive8(mk(0, 1, 1, 1, 1, 0));
        drive8(mk(0, 1, 1, 1, 2, 0));

        drive4(mk(1, 1, 1, 0, 0, 'hE));
        drive4(mk(0, 1, 1, 0, 3, 0));
        drive4(mk(0, 1, 0, 0, 3, 0));
        drive4(mk(1, 0, 0, 1, 0, 'h1));
        drive4(mk(0, 1, 0, 1, 3, 0));
        drive4(mk(0, 1, 0, 1, 3, 0));

        repeat (400) drive(rnd(), rnd());

        @(posedge clk);
        #2;
        n_vec++;
        if (q8.size() != 0 || q4.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", q8.size(), q4.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
